// File: rtl/counter_poll_pkg.sv
// Shared types and default sizing for the counter_poll sweep sequencer.
package counter_poll_pkg;

    localparam int DEF_NUM_CNT = 5;
    localparam int DEF_CNT_W   = 5;
    localparam int DEF_IDX_W   = 3;
    localparam int DEF_SUM_W   = 8;

    typedef enum logic [1:0] {
        S_WAIT = 2'd0,
        S_REQ  = 2'd1,
        S_HOLD = 2'd2,
        S_DONE = 2'd3
    } state_e;

endpackage

// File: rtl/counter_poll.sv
// Sweeps counters 0..NUM_CNT-1 of the pop-counter block and hands each value to a
// valid/ready consumer. Define COUNTER_POLL_SUM_EN to add the sweep-total output sum.
module counter_poll
    import counter_poll_pkg::*;
#(
    parameter int NUM_CNT = DEF_NUM_CNT,
    parameter int CNT_W   = DEF_CNT_W,
    parameter int IDX_W   = DEF_IDX_W,
    parameter int SUM_W   = DEF_SUM_W
) (
    input  logic             clk,
    input  logic             reset_L,
    input  logic             start,
    input  logic             IDLE,
    output logic             req,
    output logic [IDX_W-1:0] idx,
    input  logic             valid_in,
    input  logic [CNT_W-1:0] data_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [IDX_W-1:0] out_idx,
    output logic [CNT_W-1:0] out_data,
    output logic             busy,
    output logic             done
`ifdef COUNTER_POLL_SUM_EN
    ,
    output logic [SUM_W-1:0] sum
`endif
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CNT - 1);

    state_e           state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [IDX_W-1:0] out_idx_q, out_idx_d;
    logic [CNT_W-1:0] out_data_q, out_data_d;
`ifdef COUNTER_POLL_SUM_EN
    logic [SUM_W-1:0] sum_q, sum_d;
`endif

    // Next-state and datapath updates; valid_in is only honoured while requesting.
    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        out_idx_d  = out_idx_q;
        out_data_d = out_data_q;
`ifdef COUNTER_POLL_SUM_EN
        sum_d      = sum_q;
`endif
        case (state_q)
            S_WAIT: begin
                if (start) begin
                    state_d = S_REQ;
                    idx_d   = '0;
`ifdef COUNTER_POLL_SUM_EN
                    sum_d   = '0;
`endif
                end else begin
                    state_d = S_WAIT;
                end
            end
            S_REQ: begin
                if (valid_in && IDLE) begin
                    state_d    = S_HOLD;
                    out_idx_d  = idx_q;
                    out_data_d = data_in;
`ifdef COUNTER_POLL_SUM_EN
                    sum_d      = sum_q + SUM_W'(data_in);
`endif
                end else begin
                    state_d = S_REQ;
                end
            end
            S_HOLD: begin
                if (out_ready) begin
                    if (idx_q == LAST_IDX) begin
                        state_d = S_DONE;
                    end else begin
                        state_d = S_REQ;
                        idx_d   = idx_q + IDX_W'(1);
                    end
                end else begin
                    state_d = S_HOLD;
                end
            end
            S_DONE: begin
                state_d = S_WAIT;
                idx_d   = '0;
            end
            default: begin
                state_d = S_WAIT;
                idx_d   = '0;
            end
        endcase
    end

    // State and datapath registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset_L) begin
            state_q    <= S_WAIT;
            idx_q      <= '0;
            out_idx_q  <= '0;
            out_data_q <= '0;
`ifdef COUNTER_POLL_SUM_EN
            sum_q      <= '0;
`endif
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            out_idx_q  <= out_idx_d;
            out_data_q <= out_data_d;
`ifdef COUNTER_POLL_SUM_EN
            sum_q      <= sum_d;
`endif
        end
    end

    // Control outputs decode straight from the state register, never from inputs.
    assign req       = (state_q == S_REQ);
    assign out_valid = (state_q == S_HOLD);
    assign busy      = (state_q != S_WAIT);
    assign done      = (state_q == S_DONE);
    assign idx       = idx_q;
    assign out_idx   = out_idx_q;
    assign out_data  = out_data_q;
`ifdef COUNTER_POLL_SUM_EN
    assign sum       = sum_q;
`endif

endmodule

// File: doc/counter_poll.md
# counter_poll

Sequencer that sits downstream of the per-FIFO pop-counter block and reads out all of its counters in one sweep. On a start pulse it steps the counter index from 0 to NUM_CNT-1, raises the request, and waits for the counter block to answer while the design is IDLE. It captures each value and presents it to a consumer over a valid/ready handshake. At the end of the sweep it pulses done.

## Interface
- NUM_CNT, 5, number of counters swept (indices 0..NUM_CNT-1)
- CNT_W, 5, counter value width
- IDX_W, 3, index width
- SUM_W, 8, width of the sweep total (only with COUNTER_POLL_SUM_EN)

Ports:
- clk  in  1  single clock, all state updates on posedge
- reset_L  in  1  synchronous, active-low reset
- start  in  1  begin a sweep; sampled only in WAIT
- IDLE  in  1  design idle flag, also routed to the counter block
- req  out  1  read request to the counter block
- idx  out  IDX_W  counter index to the counter block
- valid_in  in  1  counter block's valid (IDLE && req)
- data_in  in  CNT_W  counter block's data_out
- out_valid  out  1  captured value available
- out_ready  in  1  consumer accepts the captured value
- out_idx  out  IDX_W  index of the captured value
- out_data  out  CNT_W  captured counter value
- busy  out  1  sweep in progress (any state except WAIT)
- done  out  1  one-cycle pulse at end of sweep
- sum  out  SUM_W  total of all captured values (macro-gated)

## Operation
- States: WAIT, REQ, HOLD, DONE.
- **WAIT:** start=1 moves to REQ. idx is loaded with 0. sum is cleared.
- **REQ:** req=1.
  - valid_in=1 at the edge captures data_in into out_data and idx into out_idx, then moves to HOLD.
  - valid_in=0 (IDLE low) stays in REQ with req held. There is no timeout.
- **HOLD:** req=0, out_valid=1, out_data/out_idx stable.
  - out_ready=1 at the edge: if idx==NUM_CNT-1, go to DONE; otherwise idx+1 and go to REQ.
  - out_ready=0: remain in HOLD.
- **DONE:** done=1 for exactly one cycle, then WAIT. idx returns to 0.
- All outputs are registered or decoded directly from the state register. req, out_valid, busy and done have no combinational path from inputs.
- Ignored inputs:
  - start outside WAIT, including start held high during a sweep.
  - valid_in outside REQ.
- idx never exceeds NUM_CNT-1 and does not wrap mid-sweep.

## Timing
- Reset values:
  - state WAIT.
  - req, out_valid, busy, done all 0.
  - idx, out_idx, out_data, sum all 0.
- Reset takes effect on the next posedge regardless of state. A mid-sweep reset aborts without a done pulse.
- start sampled at edge 0:
  - req=1 with idx=0 during cycle 1.
  - Capture at edge 1 if IDLE=1.
  - out_valid=1 during cycle 2.
- With IDLE=1 and out_ready=1 continuously, each counter costs 2 cycles. done is high during cycle 2*NUM_CNT+1 (cycle 11 for NUM_CNT=5). busy falls the cycle after done.
- An IDLE low cycle in REQ adds one cycle per stall. A low out_ready cycle in HOLD adds one cycle per stall.
- A new start is accepted in the cycle after done (state WAIT).

## Configuration
- **COUNTER_POLL_SUM_EN defined:**
  - sum accumulates data_in, zero-extended to SUM_W, at every capture.
  - sum is cleared on start and valid (stable) from the done cycle until the next start.
  - Worst case NUM_CNT*(2^CNT_W-1)=155 fits in 8 bits.
- **Not defined:** the sum port and its register are absent.

## Structure
- Shared package counter_poll_pkg holds:
  - the state enum (WAIT/REQ/HOLD/DONE, 2 bits),
  - NUM_CNT, CNT_W, IDX_W and SUM_W defaults.
- Single flat module. The accumulator is too small to justify a sub-module.

## Test plan
- **Basic sweep:** reset; counters preloaded 3,0,31,7,12; IDLE=1, out_ready=1, start pulse → out_data 3,0,31,7,12 with out_idx 0..4. done in cycle 11 after start; sum=53 when macro on.
- **IDLE stall:** IDLE=0 for 4 cycles while in REQ idx=2 → req stays 1, no capture. Capture happens on the first IDLE=1 cycle and done is delayed by 4 cycles.
- **Backpressure:** out_ready=0 for 3 cycles in HOLD idx=1 → out_valid, out_data and out_idx stay constant. idx only advances after acceptance.
- **Start handling:** start held high throughout → one sweep, then a second sweep begins the cycle after done. A start pulse mid-sweep → ignored.
- **Reset mid-operation:** reset_L=0 during HOLD idx=3 → next cycle all outputs at reset values, no done pulse. A following start begins at idx=0.
- **Spurious valid:** valid_in=1 while in WAIT or HOLD → no capture and out_data is unchanged.
